// File: rtl/nibble_serial_subtractor_ctrl.sv
// Nibble-serial wide subtractor sequencer driving an external 4-bit parallel_subtractor.
// Optional SUB_SEQ_BORROW_IN_EN adds a borrow-in port (bin) captured with the operands.
module nibble_serial_subtractor_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
`ifdef SUB_SEQ_BORROW_IN_EN
    input  logic                 bin,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 borrow,
    output logic [3:0]           sub_a,
    output logic [3:0]           sub_b,
    output logic                 sub_bin,
    input  logic [3:0]           sub_d,
    input  logic                 sub_bout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    logic [1:0]    state_q,  state_d;
    logic [W-1:0]  a_q,      a_d;
    logic [W-1:0]  b_q,      b_d;
    logic [W-1:0]  acc_q,    acc_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic          bff_q,    bff_d;
    logic [W-1:0]  result_q, result_d;
    logic          borrow_q, borrow_d;

    logic          init_bff;

`ifdef SUB_SEQ_BORROW_IN_EN
    assign init_bff = bin;
`else
    assign init_bff = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a signal unassigned (no latches).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        bff_d    = bff_q;
        result_d = result_q;
        borrow_d = borrow_q;
        sub_a    = 4'd0;
        sub_b    = 4'd0;
        sub_bin  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    bff_d   = init_bff;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sub_a   = a_q[{idx_q, 2'b00} +: 4];
                sub_b   = b_q[{idx_q, 2'b00} +: 4];
                sub_bin = bff_q;
                acc_d[{idx_q, 2'b00} +: 4] = sub_d;
                bff_d   = sub_bout;
                if (idx_q == LAST_IDX) begin
                    // Publish the accumulator with the final nibble already merged in.
                    result_d = acc_d;
                    borrow_d = sub_bout;
                    idx_d    = '0;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            bff_q    <= 1'b0;
            result_q <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            bff_q    <= bff_d;
            result_q <= result_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign borrow = borrow_q;

endmodule

// File: doc/nibble_serial_subtractor_ctrl.md
Name: nibble_serial_subtractor_ctrl

Overview:
Sequencer that sits directly upstream and downstream of the 4-bit parallel_subtractor. It subtracts two wide operands one nibble per clock, LSB nibble first. Each cycle it drives A/B/b_in of an external parallel_subtractor instance, then registers that instance's D and b_out. The borrow ripples between nibbles through a flip-flop, giving a multi-cycle wide subtractor built from the existing 4-bit stage.

Parameters:
NIBBLES, 4, operand width in nibbles (operand width W = 4*NIBBLES); legal range 2..8.

Ports:
clk      input   1     system clock; all state updates on rising edge
rst      input   1     synchronous, active-high reset
start    input   1     request; sampled only in IDLE
op_a     input   W     minuend, captured on accepted start
op_b     input   W     subtrahend, captured on accepted start
busy     output  1     high in RUN and DONE states
done     output  1     one-cycle pulse, high while state==DONE
result   output  W     op_a - op_b (mod 2^W), valid from the done cycle onward
borrow   output  1     final borrow out of the MSB nibble
sub_a    output  4     to parallel_subtractor A
sub_b    output  4     to parallel_subtractor B
sub_bin  output  1     to parallel_subtractor b_in
sub_d    input   4     from parallel_subtractor D
sub_bout input   1     from parallel_subtractor b_out

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, result=0, borrow=0. Internal a_reg, b_reg, acc, idx and bff are all cleared. Reset overrides start and aborts any operation in progress; no partial result is published.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start=1 at an edge: capture op_a->a_reg, op_b->b_reg; bff<=0; idx<=0; acc<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - sub_a = a_reg[4*idx+3:4*idx], sub_b = b_reg[same slice], sub_bin = bff. These are combinational from registers; the external subtractor is combinational.
  - Each edge: acc[4*idx+3:4*idx] <= sub_d; bff <= sub_bout; idx <= idx+1.
  - At the edge where idx==NIBBLES-1: result <= acc with the final nibble merged in; borrow <= sub_bout; go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally. start is ignored in DONE.
- Outside RUN, sub_a, sub_b and sub_bin are driven 0.
- start while busy=1 is ignored. Captured operands never change mid-operation, even if op_a/op_b change.
- result and borrow hold their previous values through RUN and update only at the RUN->DONE edge. They persist after DONE until the next completion or reset.
- Latency: start sampled at edge k; result/borrow are updated at edge k+NIBBLES; done is high in the cycle between edges k+NIBBLES and k+NIBBLES+1. The earliest next start is accepted at edge k+NIBBLES+2 (one IDLE cycle). Throughput is one operation per NIBBLES+2 cycles.
- Arithmetic: result = (op_a - op_b) mod 2^W. borrow=1 iff op_a < op_b (unsigned), or iff op_a < op_b + bin when SUB_SEQ_BORROW_IN_EN is defined.
- idx width is clog2(NIBBLES). idx never wraps in use, because RUN exits at NIBBLES-1.

Optional Feature:
Macro SUB_SEQ_BORROW_IN_EN.
- Defined: adds input port bin (1 bit), captured with the operands on an accepted start; bff is initialised to bin instead of 0. This allows cascading several controllers or chaining words.
- Undefined: no bin port; bff is initialised to 0.
All other timing is identical in both builds.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with start=1 and random operands -> busy=0, done=0, result=0x0000, borrow=0, sub_a=sub_b=0, sub_bin=0.
2. Basic: NIBBLES=4, start with op_a=0x1234, op_b=0x0234 -> done pulses exactly 4 cycles after the start edge, result=0x1000, borrow=0. Also check sub_a/sub_b sequence 4/4, 3/3, 2/2, 1/0 on successive RUN cycles.
3. Full borrow ripple: op_a=0x0000, op_b=0x0001 -> sub_bin sequence 0,1,1,1; result=0xFFFF, borrow=1. Also op_a=0x8000, op_b=0x8000 -> result=0x0000, borrow=0.
4. Busy handling: pulse start again with op_a=0xFFFF during RUN -> ignored, first result unchanged. Assert start in the DONE cycle -> ignored. Assert start in the following IDLE cycle -> accepted; second result is correct.
5. Reset mid-operation: start 0x5555-0x1111, assert rst after 2 RUN cycles -> IDLE, result stays 0x0000, no done pulse. A subsequent 0x5555-0x1111 gives 0x4444, borrow=0.
6. With SUB_SEQ_BORROW_IN_EN defined: bin=1, op_a=0x0005, op_b=0x0003 -> result=0x0001, borrow=0. Then bin=1, op_a=0x0003, op_b=0x0003 -> result=0xFFFF, borrow=1.
